// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared state type and sizing helpers for the clk_div_bank divider bank.
package clk_div_pkg;

    typedef enum logic [1:0] {ST_RESET, ST_SETTLE, ST_LOCKED, ST_STDBY} state_e;

    localparam int CH_IDX_W = 3;

    function automatic int settle_w(input int lock_cycles);
        return $clog2(lock_cycles + 1);
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel holding D/P/en, a realignable wrap counter and its
// clock-enable / square-wave decode.
module clk_div_chan #(
    parameter int   DIV_W   = 8,
    parameter int   DEF_DIV = 2,
    parameter logic DEF_EN  = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             hold_i,
    input  logic             realign_i,
    input  logic             wr_i,
    input  logic [DIV_W-1:0] cfg_div_i,
    input  logic [DIV_W-1:0] cfg_phase_i,
    input  logic             cfg_en_i,
    input  logic             locked_i,
    output logic             clk_en_o,
    output logic             clk_sq_o
);

    localparam logic [DIV_W-1:0] ONE   = 1;
    localparam logic [DIV_W:0]   ONE_W = 1;

    logic [DIV_W-1:0] div_q, div_d, phase_q, phase_d, cnt_q, cnt_d;
    logic [DIV_W-1:0] deff_q, deff_d, half;
    logic             en_q, en_d;

    always_comb begin
        div_d   = wr_i ? cfg_div_i : div_q;
        en_d    = wr_i ? cfg_en_i : en_q;
        deff_d  = (div_d == '0) ? ONE : div_d;
        deff_q  = (div_q == '0) ? ONE : div_q;
        // phase is stored already clamped so the load value never exceeds Deff-1
        phase_d = wr_i ? ((cfg_phase_i < deff_d) ? cfg_phase_i : deff_d - ONE) : phase_q;
        cnt_d   = hold_i    ? cnt_q :
                  realign_i ? ((phase_d == '0) ? '0 : deff_d - phase_d) :
                  (cnt_q >= deff_q - ONE) ? '0 : cnt_q + ONE;
        half    = DIV_W'(({1'b0, deff_q} + ONE_W) >> 1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            div_q   <= DIV_W'(DEF_DIV);
            phase_q <= '0;
            en_q    <= DEF_EN;
            cnt_q   <= '0;
        end else begin
            div_q   <= div_d;
            phase_q <= phase_d;
            en_q    <= en_d;
            cnt_q   <= cnt_d;
        end
    end

    assign clk_en_o = locked_i & en_q & (cnt_q == '0);
    assign clk_sq_o = locked_i & en_q & (cnt_q < half);

endmodule

// File: rtl/clk_div_bank.sv
// clk_div_bank: bank of NUM_CH programmable clock-enable dividers with a settle/lock FSM,
// standby and a valid/ready configuration port.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int                NUM_CH      = 5,
    parameter int                DIV_W       = 8,
    parameter int                LOCK_CYCLES = 64,
    parameter int                DEF_DIV     = 2,
    parameter logic [NUM_CH-1:0] DEF_EN      = '1
) (
    input  logic                refclk_i,
    input  logic                rst_n_i,
    input  logic                stdby_i,
    input  logic                cfg_valid_i,
    output logic                cfg_ready_o,
    input  logic [CH_IDX_W-1:0] cfg_ch_i,
    input  logic [DIV_W-1:0]    cfg_div_i,
    input  logic [DIV_W-1:0]    cfg_phase_i,
    input  logic                cfg_en_i,
    output logic                cfg_err_o,
    output logic [NUM_CH-1:0]   clk_en_o,
    output logic [NUM_CH-1:0]   clk_sq_o,
    output logic                locked_o
);

    localparam int SW = settle_w(LOCK_CYCLES);
    // settle_q reads 0 on the cycle after realign, so lock is entered one count early
    localparam logic [SW-1:0] SETTLE_LAST = SW'(LOCK_CYCLES > 1 ? LOCK_CYCLES - 2 : 0);
    localparam logic [SW-1:0] S_ONE       = 1;

    state_e            state_q, state_d;
    logic [SW-1:0]     settle_q, settle_d;
    logic              locked_q, cfg_err_q;
    logic              accept, ch_ok, realign, hold;
    logic [NUM_CH-1:0] wr;

    assign cfg_ready_o = rst_n_i & ~stdby_i & (state_q == ST_SETTLE || state_q == ST_LOCKED);
    assign accept      = cfg_valid_i & cfg_ready_o;
    assign ch_ok       = int'(cfg_ch_i) < NUM_CH;
    assign hold        = rst_n_i & stdby_i;
    assign realign     = rst_n_i & ~stdby_i &
                         (state_q == ST_RESET || state_q == ST_STDBY || (accept & ch_ok));

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        if (realign) begin
            state_d  = (LOCK_CYCLES == 1) ? ST_LOCKED : ST_SETTLE;
            settle_d = '0;
        end else if (stdby_i) begin
            state_d  = ST_STDBY;
        end else if (state_q == ST_SETTLE) begin
            settle_d = settle_q + S_ONE;
            state_d  = (settle_q == SETTLE_LAST) ? ST_LOCKED : ST_SETTLE;
        end
    end

    always_ff @(posedge refclk_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_RESET;
            settle_q  <= '0;
            locked_q  <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            locked_q  <= (state_d == ST_LOCKED);
            cfg_err_q <= accept & ~ch_ok;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign wr[i] = accept & ch_ok & (cfg_ch_i == CH_IDX_W'(i));
        clk_div_chan #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DEF_DIV),
            .DEF_EN  (DEF_EN[i])
        ) u_chan (
            .clk_i       (refclk_i),
            .rst_n_i     (rst_n_i),
            .hold_i      (hold),
            .realign_i   (realign),
            .wr_i        (wr[i]),
            .cfg_div_i   (cfg_div_i),
            .cfg_phase_i (cfg_phase_i),
            .cfg_en_i    (cfg_en_i),
            .locked_i    (locked_q),
            .clk_en_o    (clk_en_o[i]),
            .clk_sq_o    (clk_sq_o[i])
        );
    end

    assign locked_o  = locked_q;
    assign cfg_err_o = cfg_err_q;

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Parametrised, fabric-based successor to the fixed two-output hard PLL wrapper. From one reference clock, it produces `NUM_CH` phase-aligned clock-enable pulses and square-wave strobes. Each channel has a runtime-programmable divider, phase, and enable. A lock/settle state machine, a standby mode and a configuration handshake replace the hard PLL's static parameters. It sits between board clock input and the SoC, driving peripheral and bus clock enables without extra global clocks.

## Interface
- `NUM_CH`, 5, number of output channels (1..8)
- `DIV_W`, 8, divider/phase register width
- `LOCK_CYCLES`, 64, settle cycles before `locked` asserts (≥1)
- `DEF_DIV`, 2, post-reset divide ratio of every channel
- `DEF_EN`, all ones, post-reset channel enable mask (`NUM_CH` bits)

Ports:
- `refclk`  in  1  sole clock; all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `stdby`  in  1  standby request, level
- `cfg_valid`  in  1  config write request
- `cfg_ready`  out  1  config write accepted when `cfg_valid & cfg_ready`
- `cfg_ch`  in  3  target channel index
- `cfg_div`  in  DIV_W  divide ratio D
- `cfg_phase`  in  DIV_W  phase offset P, in `refclk` cycles
- `cfg_en`  in  1  channel enable
- `cfg_err`  out  1  one-cycle pulse: write to `cfg_ch ≥ NUM_CH`
- `clk_en`  out  NUM_CH  one-cycle enable pulse per period
- `clk_sq`  out  NUM_CH  ~50 % duty strobe per channel
- `locked`  out  1  outputs valid and aligned

## Operation
- States: RESET, SETTLE, LOCKED, STDBY.
- RESET (`rst_n`=0): all outputs 0. Channel registers load D=`DEF_DIV`, P=0, en=`DEF_EN[i]`. Settle counter is cleared.
- Realign event: first cycle with `rst_n`=1, an accepted valid write, or the first cycle after `stdby` falls. On a realign event:
  - every channel counter loads `(P==0) ? 0 : Deff−P`;
  - the settle counter clears;
  - state becomes SETTLE.
- Effective values:
  - Deff = max(D,1);
  - Peff = min(P, Deff−1);
  - P is clamped at write time.
- Counter behaviour: each channel counter increments every cycle and wraps from Deff−1 to 0.
- Output decode:
  - `clk_en[i]` = locked & en & (cnt==0);
  - `clk_sq[i]` = locked & en & (cnt < ⌈Deff/2⌉).
  - With D=1: `clk_en` is constantly 1 and `clk_sq` is constantly 1.
- SETTLE: counts cycles. After `LOCK_CYCLES` cycles it moves to LOCKED (`locked`=1). Channel counters run during SETTLE, but outputs are gated to 0.
- LOCKED: steady state.
- Valid write (SETTLE or LOCKED, `cfg_ch<NUM_CH`): the register update and the realign event occur in the same cycle. `locked` drops the next cycle.
- Invalid channel: the write is accepted and `cfg_err` pulses. There is no register change and no realign.
- `stdby`=1 in any non-reset state: state becomes STDBY. Counters freeze, and all outputs and `cfg_ready` are 0.
- `cfg_ready` = 1 in SETTLE and LOCKED, 0 in RESET and STDBY.
- Precedence: `rst_n` > `stdby` > cfg write. A write presented in the same cycle `stdby` rises is not accepted.

## Timing
- Realign at cycle T0:
  - counters hold their load value at T0+1;
  - `locked` is 1 from T0+LOCK_CYCLES;
  - the first `clk_en` pulse is the first cycle ≥ T0+LOCK_CYCLES where cnt==0.
- Phase offset: with P=k<Deff, channel `clk_en` pulses occur k cycles after those of a P=0 channel of equal D.
- Output registers:
  - `cfg_err` is registered, 1-cycle latency after acceptance;
  - `locked` is registered;
  - `clk_en`/`clk_sq` are decodes of registered state and must feed only registered logic.
- `rst_n` asserted mid-SETTLE or mid-LOCKED: all outputs are 0 on the next edge.

## Structure
- Package `clk_div_pkg`:
  - state enum (2 bits);
  - `CH_IDX_W`=3;
  - settle counter width `$clog2(LOCK_CYCLES+1)`.
- Sub-module `clk_div_chan`, instantiated `NUM_CH` times. It contains the D/P/en registers, the load-on-realign logic, the counter and the output decode.
- Top level contains the FSM, the settle counter, config decode and `cfg_err`.

## Test plan
- Reset release with defaults (D=2, all enabled, LOCK_CYCLES=64):
  - `locked` rises exactly 64 cycles after the first `rst_n`=1 cycle;
  - all `clk_en` then pulse every 2 cycles, in phase.
- Write ch1 D=8 P=3 and ch0 D=8 P=0 (back-to-back writes):
  - `locked` drops, then relocks 64 cycles after the second write;
  - ch1 pulses lag ch0 by 3 cycles;
  - `clk_sq[1]` is high for 4 of 8 cycles.
- Write D=0 to ch2: ch2 `clk_en` is held at 1 while locked. Write D=5: `clk_sq` is high 3 of 5 cycles.
- Write `cfg_ch`=6 with NUM_CH=5:
  - `cfg_err`=1 for one cycle;
  - `locked` stays 1;
  - outputs are unchanged.
- Raise `stdby` for 10 cycles while locked:
  - outputs, `locked` and `cfg_ready` are 0;
  - after `stdby` falls, relock occurs after 64 cycles, with counters realigned.
- Assert `rst_n`=0 mid-SETTLE following a write: next cycle all outputs are 0 and registers hold defaults.
